// File: rtl/uart_pkg.sv
// Shared definitions for the two-frame UART command link (receiver and transmitter).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } uart_state_e;

   localparam int FRAME_DATA_BITS = 8;
   localparam int FRAME_BITS      = 11;

   function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus mid-bit sample tick generator for the UART receiver.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_i,
   input  logic run_i,
   input  logic load_half_i,
   output logic rx_s_o,
   output logic tick_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;

   // Two-flop synchroniser, idles high so a reset line never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

   assign rx_s_o = sync_q[1];
   assign tick_o = run_i && (cnt_q == '0);

   // Down-counter: first tick half a bit after the start edge, then one per bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_half_i) begin
         cnt_q <= HALF_LOAD;
      end else if (tick_o) begin
         cnt_q <= FULL_LOAD;
      end else if (run_i) begin
         cnt_q <= cnt_q - CW'(1);
      end else begin
         cnt_q <= '0;
      end
   end

endmodule

// File: rtl/uart_cmd_rx.sv
// Two-frame UART command receiver: assembles {frame0, frame1} into a 16-bit command
// with a valid/ready output and one-cycle error pulses.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_BITS = 22
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [15:0] cmd_out,
   output logic        cmd_vld,
   input  logic        cmd_rdy,
   output logic        parity_err,
   output logic        frame_err,
   output logic        timeout_err,
   output logic        overrun
);

   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW       = $clog2(TO_LIMIT + 1);

   uart_state_e                state_q;
   logic [FRAME_DATA_BITS-1:0] shift_q;
   logic [FRAME_DATA_BITS-1:0] byte0_q;
   logic [2:0]                 bit_idx_q;
   logic                       byte_idx_q;
   logic                       par_q;
   logic [TW-1:0]              to_cnt_q;

   logic rx_s;
   logic tick;
   logic load_half;
   logic run;

   assign load_half = (state_q == ST_IDLE) && !rx_s;
   assign run       = (state_q != ST_IDLE) && (state_q != ST_WAIT_HIGH);

   uart_rx_sampler #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_i       (rx),
      .run_i      (run),
      .load_half_i(load_half),
      .rx_s_o     (rx_s),
      .tick_o     (tick)
   );

   // Frame FSM, byte assembly, inter-frame timeout and output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         byte0_q     <= '0;
         bit_idx_q   <= 3'd0;
         byte_idx_q  <= 1'b0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         cmd_out     <= 16'h0000;
         cmd_vld     <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
         if (cmd_vld && cmd_rdy) begin
            cmd_vld <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_q  <= ST_START;
                  to_cnt_q <= '0;
               end else if (byte_idx_q) begin
                  if (to_cnt_q == TW'(TO_LIMIT)) begin
                     timeout_err <= 1'b1;
                     byte_idx_q  <= 1'b0;
                     to_cnt_q    <= '0;
                  end else begin
                     to_cnt_q <= to_cnt_q + TW'(1);
                  end
               end else begin
                  to_cnt_q <= '0;
               end
            end
            ST_START: begin
               // A high line at mid start bit was a glitch; keep the pending byte.
               if (tick) begin
                  if (rx_s) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q   <= ST_DATA;
                     bit_idx_q <= 3'd0;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shift_q   <= {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'(FRAME_DATA_BITS - 1)) begin
                     state_q <= ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  par_q   <= rx_s;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (!rx_s) begin
                     frame_err  <= 1'b1;
                     byte_idx_q <= 1'b0;
                     state_q    <= ST_WAIT_HIGH;
                  end else if (par_q != odd_parity(shift_q)) begin
                     parity_err <= 1'b1;
                     byte_idx_q <= 1'b0;
                     state_q    <= ST_IDLE;
                  end else if (!byte_idx_q) begin
                     byte0_q    <= shift_q;
                     byte_idx_q <= 1'b1;
                     state_q    <= ST_IDLE;
                  end else begin
                     byte_idx_q <= 1'b0;
                     state_q    <= ST_IDLE;
                     // Same-cycle accept frees the slot; otherwise a held command wins.
                     if (!cmd_vld || cmd_rdy) begin
                        cmd_out <= {byte0_q, shift_q};
                        cmd_vld <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (rx_s) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_cmd_rx;

   localparam int CPB   = 16;
   localparam int TOB   = 22;
   localparam int NBITS = 11;
   // Start edge to cmd_vld: sync (2) + detect (1) + half bit + ten bit periods.
   localparam int LAT   = 3 + CPB / 2 + 10 * CPB;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        rx      = 1'b1;
   logic        cmd_rdy = 1'b1;
   logic [15:0] cmd_out;
   logic        cmd_vld;
   logic        parity_err;
   logic        frame_err;
   logic        timeout_err;
   logic        overrun;

   always #5 clk = ~clk;

   uart_cmd_rx #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_BITS(TOB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .cmd_out    (cmd_out),
      .cmd_vld    (cmd_vld),
      .cmd_rdy    (cmd_rdy),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .timeout_err(timeout_err),
      .overrun    (overrun)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Observed events
   int n_perr = 0, n_ferr = 0, n_to = 0, n_ovr = 0;
   int vld_rise_cyc = -1, vld_run = 0, last_run = 0;
   logic vld_prev = 1'b0;
   logic [15:0] got_q[$];

   // Reference model state
   int e_perr = 0, e_ferr = 0, e_to = 0, e_ovr = 0;
   logic        pend = 1'b0;
   logic [7:0]  pend_byte = 8'h00;
   logic        model_block = 1'b0;
   logic [15:0] exp_q[$];
   int          frame_start_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         vld_prev = 1'b0;
      end else begin
         if (parity_err)  n_perr++;
         if (frame_err)   n_ferr++;
         if (timeout_err) n_to++;
         if (overrun)     n_ovr++;
         if (cmd_vld && cmd_rdy) got_q.push_back(cmd_out);
         if (cmd_vld && !vld_prev) begin
            vld_rise_cyc = cyc;
            vld_run      = 0;
         end
         if (cmd_vld) vld_run++;
         else if (vld_prev) last_run = vld_run;
         vld_prev = cmd_vld;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                             input logic rdy_pulse);
      logic [10:0] bits;
      logic        p;
      p    = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
      p    = p ^ bad_par;
      bits = {stop, p, b, 1'b0};
      frame_start_cyc = cyc;
      for (int k = 0; k < NBITS * CPB; k++) begin
         rx = bits[k / CPB];
         if (rdy_pulse) cmd_rdy = (k == LAT - 1) ? 1'b1 : 1'b0;
         tick();
      end
      rx = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      if (!stop) begin
         e_ferr++;
         pend = 1'b0;
      end else if (bad_par) begin
         e_perr++;
         pend = 1'b0;
      end else if (!pend) begin
         pend      = 1'b1;
         pend_byte = b;
      end else begin
         pend = 1'b0;
         if (model_block) e_ovr++;
         else exp_q.push_back({pend_byte, b});
      end
   endtask

   task automatic frame(input logic [7:0] b, input logic bad_par, input logic stop, input int gap);
      int g;
      g = gap;
      if (!stop && g < CPB) g = CPB;
      send_frame(b, bad_par, stop, 1'b0);
      model_frame(b, bad_par, stop);
      idle(g);
      if (pend && g > TOB * CPB) begin
         e_to++;
         pend = 1'b0;
      end
   endtask

   task automatic verify(input string tag, input logic chk_q);
      check_eq({tag, ".perr"}, n_perr, e_perr);
      check_eq({tag, ".ferr"}, n_ferr, e_ferr);
      check_eq({tag, ".tout"}, n_to, e_to);
      check_eq({tag, ".ovr"}, n_ovr, e_ovr);
      if (chk_q) begin
         check_eq({tag, ".qlen"}, got_q.size(), exp_q.size());
         while (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, ".cmd"}, got_q.pop_front(), exp_q.pop_front());
         got_q.delete();
         exp_q.delete();
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.cmd_out", cmd_out, 16'h0000);
      check_eq("rst.cmd_vld", cmd_vld, 1'b0);
      check_eq("rst.pulses", {parity_err, frame_err, timeout_err, overrun}, 4'b0000);
      rst_n = 1'b1;
      idle(8);

      // Basic pair, latency and single-cycle valid
      frame(8'hA5, 1'b0, 1'b1, 2);
      last_run = 0;
      frame(8'h3C, 1'b0, 1'b1, 0);
      check_eq("basic.latency", vld_rise_cyc - frame_start_cyc, LAT);
      check_eq("basic.vld_width", last_run, 1);
      verify("basic", 1'b1);

      // Parity error kills the pair
      frame(8'h12, 1'b0, 1'b1, 0);
      frame(8'h34, 1'b1, 1'b1, 4);
      check_eq("parity.vld", cmd_vld, 1'b0);
      verify("parity", 1'b1);
      frame(8'hBE, 1'b0, 1'b1, 0);
      frame(8'hEF, 1'b0, 1'b1, 4);
      verify("parity_recover", 1'b1);

      // Start-bit glitch
      rx = 1'b0;
      repeat (5) tick();
      idle(2 * CPB);
      check_eq("glitch.vld", cmd_vld, 1'b0);
      verify("glitch", 1'b1);
      frame(8'h01, 1'b0, 1'b1, 0);
      frame(8'h02, 1'b0, 1'b1, 4);
      verify("glitch_recover", 1'b1);

      // Inter-frame timeout
      frame(8'h55, 1'b0, 1'b1, (TOB + 2) * CPB);
      verify("timeout", 1'b1);
      frame(8'h77, 1'b0, 1'b1, 0);
      frame(8'h88, 1'b0, 1'b1, 4);
      verify("timeout_recover", 1'b1);

      // Overrun while the consumer stalls, then same-cycle accept and reload
      cmd_rdy = 1'b0;
      frame(8'h11, 1'b0, 1'b1, 0);
      frame(8'h11, 1'b0, 1'b1, 4);
      check_eq("stall.vld", cmd_vld, 1'b1);
      check_eq("stall.cmd", cmd_out, 16'h1111);
      verify("stall", 1'b0);
      model_block = 1'b1;
      frame(8'h22, 1'b0, 1'b1, 0);
      frame(8'h22, 1'b0, 1'b1, 4);
      model_block = 1'b0;
      check_eq("ovr.vld", cmd_vld, 1'b1);
      check_eq("ovr.cmd", cmd_out, 16'h1111);
      verify("ovr", 1'b0);
      frame(8'h22, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      model_frame(8'h22, 1'b0, 1'b1);
      idle(4);
      check_eq("same_cycle.vld", cmd_vld, 1'b1);
      check_eq("same_cycle.cmd", cmd_out, 16'h2222);
      verify("same_cycle", 1'b0);
      cmd_rdy = 1'b1;
      idle(4);
      verify("drain", 1'b1);

      // Asynchronous reset in the middle of frame1
      frame(8'h12, 1'b0, 1'b1, 0);
      rx = 1'b0;
      repeat (3 * CPB) tick();
      rst_n = 1'b0;
      #1;
      check_eq("midrst.cmd_out", cmd_out, 16'h0000);
      check_eq("midrst.cmd_vld", cmd_vld, 1'b0);
      check_eq("midrst.pulses", {parity_err, frame_err, timeout_err, overrun}, 4'b0000);
      repeat (3) tick();
      rx    = 1'b1;
      rst_n = 1'b1;
      pend  = 1'b0;
      idle(8);
      frame(8'hCA, 1'b0, 1'b1, 0);
      frame(8'hFE, 1'b0, 1'b1, 4);
      verify("midrst", 1'b1);

      // Stop bit low followed by a break: exactly one frame error
      frame(8'h5A, 1'b0, 1'b1, 0);
      send_frame(8'h6B, 1'b0, 1'b0, 1'b0);
      model_frame(8'h6B, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (12 * CPB) tick();
      idle(2 * CPB);
      verify("break", 1'b1);
      frame(8'h09, 1'b0, 1'b1, 0);
      frame(8'h06, 1'b0, 1'b1, 4);
      verify("break_recover", 1'b1);

      // Random frames with occasional parity, stop and timeout faults
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         logic       bp;
         logic       st;
         int         gap;
         b   = 8'($urandom);
         bp  = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
         st  = ($urandom_range(0, 11) == 0) ? 1'b0 : 1'b1;
         gap = ($urandom_range(0, 9) == 0) ? (TOB + 2) * CPB : int'($urandom_range(0, 2 * CPB));
         frame(b, bp, st, gap);
         verify("rand", 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
